// File: rtl/arbitro_datapath_pkg.sv
// Shared definitions for the datapath arbiter:
// state encodings, default timeout, output bundle.
package arbitro_datapath_pkg;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] INICIA  = 3'd1;
  localparam logic [2:0] AGUARDA = 3'd2;
  localparam logic [2:0] CONCLUI = 3'd3;
  localparam logic [2:0] ERRO    = 3'd4;

  localparam int TIMEOUT_DEF = 16;

  typedef struct packed {
    logic inicio;
    logic gnt0;
    logic gnt1;
    logic done0;
    logic done1;
    logic erro;
    logic ocupado;
    logic sel_req;
  } saidas_t;

  // Lone requester wins; on a tie the one that did not go last wins.
  function automatic logic escolhe(
    input logic r0,
    input logic r1,
    input logic ult
  );
    return (r0 & r1) ? ~ult : r1;
  endfunction

endpackage

// File: rtl/arbitro_datapath_detector_borda.sv
// Rising-edge detector on a registered copy of the input.
// The copy resets high so a level already present is not an edge.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic borda
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_d;
    end
  end

  assign borda = d & ~d_q;

endmodule

// File: rtl/arbitro_datapath.sv
// Round-robin owner of the shared polynomial datapath:
// launch, wait for pronto, report done or timeout.
module arbitro_datapath
  import arbitro_datapath_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic pronto,
  output logic inicio,
  output logic rst_dp,
  output logic sel_req,
  output logic gnt0,
  output logic gnt1,
  output logic done0,
  output logic done1,
  output logic erro,
  output logic ocupado
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       estado_q, estado_d;
  logic             ult_q, ult_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  saidas_t          out_q, out_d;
  logic             borda;
  logic             w;
  logic             ativo_d;
  logic             fim_d;

  detector_borda u_borda (
    .clk   (clk),
    .rst   (rst),
    .d     (pronto),
    .borda (borda)
  );

  always_comb begin
    estado_d = estado_q;
    ult_d    = ult_q;
    cnt_d    = cnt_q;
    w        = out_q.sel_req;
    unique case (estado_q)
      OCIOSO: begin
        if (req0 | req1) begin
          w        = escolhe(req0, req1, ult_q);
          estado_d = INICIA;
        end
      end
      INICIA: begin
        cnt_d    = '0;
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        cnt_d = cnt_q + 1'b1;
        // A completion edge beats a simultaneous timeout.
        if (borda) begin
          estado_d = CONCLUI;
        end else if (cnt_q == CNT_MAX) begin
          estado_d = ERRO;
        end
      end
      CONCLUI, ERRO: begin
        ult_d    = out_q.sel_req;
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_comb begin
    ativo_d       = (estado_d != OCIOSO);
    fim_d         = (estado_d == CONCLUI) ||
                    (estado_d == ERRO);
    out_d         = '0;
    out_d.inicio  = (estado_d == INICIA);
    out_d.gnt0    = ativo_d & ~w;
    out_d.gnt1    = ativo_d & w;
    out_d.done0   = fim_d & ~w;
    out_d.done1   = fim_d & w;
    out_d.erro    = (estado_d == ERRO);
    out_d.ocupado = ativo_d;
    out_d.sel_req = w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      ult_q    <= 1'b1;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      estado_q <= estado_d;
      ult_q    <= ult_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign inicio  = out_q.inicio;
  assign gnt0    = out_q.gnt0;
  assign gnt1    = out_q.gnt1;
  assign done0   = out_q.done0;
  assign done1   = out_q.done1;
  assign erro    = out_q.erro;
  assign ocupado = out_q.ocupado;
  assign sel_req = out_q.sel_req;
  assign rst_dp  = rst | (estado_q == ERRO);

endmodule

// File: tb/tb_arbitro_datapath.sv
// Bench for arbitro_datapath: transaction-level model,
// per-cycle compare, directed scenarios then random traffic.
module tb_arbitro_datapath;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst, req0, req1, pronto;
  logic inicio, rst_dp, sel_req, gnt0, gnt1;
  logic done0, done1, erro, ocupado;

  always #5 clk = ~clk;

  arbitro_datapath #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .pronto  (pronto),
    .inicio  (inicio),
    .rst_dp  (rst_dp),
    .sel_req (sel_req),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .erro    (erro),
    .ocupado (ocupado)
  );

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Model: a run is "busy" from grant; age 0 is the launch cycle,
  // ages 1..TO are the waiting cycles; fin marks the closing cycle.
  bit m_busy, m_owner, m_last, m_prev, m_e;
  int m_age, m_fin;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_fin = 0; m_age = 0;
      m_owner = 0; m_last = 1; m_prev = 1;
    end else begin
      m_e = pronto && !m_prev;
      m_prev = pronto;
      if (!m_busy) begin
        if (req0 || req1) begin
          if (req0 && req1) m_owner = !m_last;
          else m_owner = req1;
          m_busy = 1; m_age = 0; m_fin = 0;
        end
      end else if (m_fin != 0) begin
        m_busy = 0; m_fin = 0; m_last = m_owner;
      end else if (m_age == 0) m_age = 1;
      else if (m_e) m_fin = 1;
      else if (m_age == TO) m_fin = 2;
      else m_age = m_age + 1;
    end
  end

  int mchecks = 0, merrs = 0;
  int lchecks = 0, lerrs = 0;
  int ini_cyc, done_cyc, dcount = 0;
  bit last_erro, last_rstdp, gnt1_seen;
  int done_log[$];
  int sel_log[$];
  logic [8:0] act_v, exp_v;

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_v = {m_busy && m_age == 0 && m_fin == 0,
               m_busy && !m_owner, m_busy && m_owner,
               m_fin != 0 && !m_owner, m_fin != 0 && m_owner,
               m_fin == 2, m_busy, m_owner,
               rst || m_fin == 2};
      act_v = {inicio, gnt0, gnt1, done0, done1,
               erro, ocupado, sel_req, rst_dp};
      mchecks++;
      if (act_v !== exp_v) begin
        merrs++;
        $display("FAIL cycle %0d outs(ini,g0,g1,d0,d1,er,oc,sel,rdp) act=%b exp=%b",
                 cyc, act_v, exp_v);
      end
      if (inicio) begin
        ini_cyc = cyc;
        sel_log.push_back(int'(sel_req));
      end
      if (done0 || done1) begin
        done_log.push_back(int'(done1));
        done_cyc = cyc;
        dcount++;
        last_erro = erro;
        last_rstdp = rst_dp;
      end
      if (gnt1) gnt1_seen = 1;
    end
  end

  // Datapath stand-in: raise pronto dp_delay cycles after launch
  int dp_delay = 6;
  int mode = 0;
  bit hold_hi = 0;
  int tcount = 0;
  bit run = 0;

  always @(negedge clk) begin
    if (inicio) begin
      tcount = 0; run = 1;
    end else if (run) tcount++;
    if (done0 || done1 || rst) begin
      run = 0; pronto = hold_hi;
    end else if (run) begin
      if (mode == 2 && tcount == 5) pronto = 0;
      if (dp_delay != 0 && tcount == dp_delay) pronto = 1;
    end else pronto = hold_hi;
  end

  task automatic chk(input string nm, input int act, input int exp);
    lchecks++;
    if (act !== exp) begin
      lerrs++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target, input int maxc);
    int n = 0;
    while (dcount < target && n < maxc) begin
      step(1);
      n++;
    end
    lchecks++;
    if (dcount < target) begin
      lerrs++;
      $display("FAIL wait_done act=%0d exp=%0d", dcount, target);
    end
  endtask

  task automatic wait_gnt(input bit who, input int maxc);
    int n = 0;
    while (!(who ? gnt1 : gnt0) && n < maxc) begin
      step(1);
      n++;
    end
    chk("wait_gnt", int'(who ? gnt1 : gnt0), 1);
  endtask

  int c0, base;
  int exp_seq[4] = '{0, 1, 0, 1};

  initial begin
    rst = 1; req0 = 0; req1 = 0; pronto = 0;
    step(2);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_gnt0", int'(gnt0), 0);
    chk("rst_rstdp", int'(rst_dp), 1);

    // single requester, completion 6 cycles after launch
    rst = 0; req0 = 1; gnt1_seen = 0; c0 = cyc;
    wait_dones(dcount + 1, 60);
    req0 = 0;
    chk("t1_start", ini_cyc - c0, 1);
    chk("t1_lat", done_cyc - ini_cyc, 7);
    chk("t1_who", done_log[$], 0);
    chk("t1_erro", int'(last_erro), 0);
    chk("t1_gnt1", int'(gnt1_seen), 0);
    step(3);

    // both requesters held: strict alternation
    rst = 1; step(1); rst = 0;
    dp_delay = 4; done_log.delete(); sel_log.delete();
    req0 = 1; req1 = 1;
    wait_dones(dcount + 4, 200);
    req0 = 0; req1 = 0;
    chk("t2_count", done_log.size(), 4);
    if (done_log.size() >= 4 && sel_log.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2_done%0d", i), done_log[i], exp_seq[i]);
        chk($sformatf("t2_sel%0d", i), sel_log[i], exp_seq[i]);
      end
    step(3);

    // pronto never comes: timeout
    dp_delay = 0; req1 = 1;
    wait_dones(dcount + 1, 60);
    chk("t3_gnt1_low", int'(gnt1), 0);
    req1 = 0;
    chk("t3_erro", int'(last_erro), 1);
    chk("t3_rstdp", int'(last_rstdp), 1);
    chk("t3_who", done_log[$], 1);
    chk("t3_lat", done_cyc - ini_cyc, 17);
    step(3);

    // pronto high at launch, fresh edge on the last waiting cycle
    dp_delay = 16; mode = 2; hold_hi = 1;
    step(2);
    req0 = 1;
    wait_dones(dcount + 1, 60);
    req0 = 0;
    chk("t4_lat", done_cyc - ini_cyc, 17);
    chk("t4_erro", int'(last_erro), 0);
    chk("t4_who", done_log[$], 0);
    hold_hi = 0; mode = 0;
    step(3);

    // requester drops mid-run
    dp_delay = 8; req1 = 1;
    wait_gnt(1, 20);
    step(2);
    req1 = 0; base = dcount;
    wait_dones(base + 1, 40);
    chk("t5_who", done_log[$], 1);
    chk("t5_erro", int'(last_erro), 0);
    step(5);
    chk("t5_once", dcount - base, 1);
    chk("t5_idle", int'(ocupado), 0);

    // reset mid-wait, then a tie goes to req0
    dp_delay = 0; req0 = 1;
    wait_gnt(0, 20);
    req0 = 0;
    step(5);
    base = dcount;
    rst = 1; req0 = 1; req1 = 1;
    step(1);
    chk("t6_gnt0_off", int'(gnt0), 0);
    chk("t6_ocup_off", int'(ocupado), 0);
    chk("t6_rstdp", int'(rst_dp), 1);
    rst = 0;
    step(1);
    chk("t6_nodone", dcount - base, 0);
    chk("t6_tie_sel", int'(sel_req), 0);
    chk("t6_tie_gnt0", int'(gnt0), 1);
    req0 = 0; req1 = 0;
    wait_dones(dcount + 1, 40);
    step(3);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 6) req0 = ~req0;
      if ($urandom_range(0, 99) < 6) req1 = ~req1;
      rst = ($urandom_range(0, 299) == 0);
      if (i % 23 == 0) dp_delay = $urandom_range(0, 18);
      step(1);
    end
    rst = 0; req0 = 0; req1 = 0;
    step(25);

    $display("Simulation finished: %0d checks, %0d errors",
             mchecks + lchecks, merrs + lerrs);
    $finish;
  end

endmodule
